// File: rtl/kv_cache_pkg.sv
// Shared types and width helpers for the multi-head KV cache.
package kv_cache_pkg;

  localparam int unsigned KV_DATA_WIDTH = 16;

  typedef struct packed {
    logic [KV_DATA_WIDTH-1:0] k;
    logic [KV_DATA_WIDTH-1:0] v;
  } kv_word_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } scan_state_t;

  function automatic int unsigned kv_hw(input int unsigned num_heads);
    return (num_heads > 1) ? $clog2(num_heads) : 1;
  endfunction

  function automatic int unsigned kv_pw(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned kv_cw(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kv_stream_skid.sv
// Two-entry valid/ready skid buffer for scan beats {word, pos, last}, with flush.
module kv_stream_skid
  import kv_cache_pkg::*;
#(
  parameter type         word_t = kv_word_t,
  parameter int unsigned PW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  word_t         in_word,
  input  logic [PW-1:0] in_pos,
  input  logic          in_last,
  output logic [1:0]    level,
  output logic          out_valid,
  input  logic          out_ready,
  output word_t         out_word,
  output logic [PW-1:0] out_pos,
  output logic          out_last
);

  typedef struct packed {
    word_t         word;
    logic [PW-1:0] pos;
    logic          last;
  } beat_t;

  beat_t e0, e1, in_b;
  logic  v0, v1, pop;

  assign in_b      = '{word: in_word, pos: in_pos, last: in_last};
  assign pop       = v0 && out_ready;
  assign level     = {1'b0, v0} + {1'b0, v1};
  assign out_valid = v0;
  assign out_word  = e0.word;
  assign out_pos   = e0.pos;
  assign out_last  = e0.last;

  // e0 is the presented beat; it only changes on pop or when empty, so stalls hold it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      e0 <= '0;
      e1 <= '0;
    end else if (flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (pop) begin
      if (v1) begin
        e0 <= e1;
        v1 <= in_valid;
        if (in_valid) e1 <= in_b;
      end else begin
        v0 <= in_valid;
        if (in_valid) e0 <= in_b;
      end
    end else if (!v0) begin
      v0 <= in_valid;
      if (in_valid) e0 <= in_b;
    end else if (in_valid) begin
      v1 <= 1'b1;
      e1 <= in_b;
    end
  end

endmodule

// File: rtl/kv_cache_mh.sv
// Multi-head append-only K/V cache with streamed whole-head scans.
// KV_CACHE_SLIDING_WINDOW_EN turns each head into a ring buffer that overwrites its oldest entry.
module kv_cache_mh
  import kv_cache_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = KV_DATA_WIDTH,
  parameter  int unsigned DEPTH      = 256,
  parameter  int unsigned NUM_HEADS  = 4,
  localparam int unsigned HW         = kv_hw(NUM_HEADS),
  localparam int unsigned PW         = kv_pw(DEPTH),
  localparam int unsigned CW         = kv_cw(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    app_valid,
  output logic                    app_ready,
  input  logic [HW-1:0]           app_head,
  input  logic [DATA_WIDTH-1:0]   app_k,
  input  logic [DATA_WIDTH-1:0]   app_v,
  input  logic                    scan_start,
  input  logic [HW-1:0]           scan_head,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_k,
  output logic [DATA_WIDTH-1:0]   out_v,
  output logic [PW-1:0]           out_pos,
  output logic                    out_last,
  output logic [NUM_HEADS*CW-1:0] fill_count
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] k;
    logic [DATA_WIDTH-1:0] v;
  } word_t;

  localparam logic [HW:0]   NH_L     = (HW+1)'(NUM_HEADS);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [CW-1:0] count  [NUM_HEADS];
  logic [PW-1:0] wptr   [NUM_HEADS];
`ifdef KV_CACHE_SLIDING_WINDOW_EN
  logic [PW-1:0] oldest [NUM_HEADS];
`endif

  word_t mem [NUM_HEADS*DEPTH];

  scan_state_t   state, state_d;
  logic [HW-1:0] sc_head;
  logic [CW-1:0] sc_len;
  logic [PW-1:0] sc_base, sc_idx, scan_base;
  logic          done_d, issue, space, last_issue, start_ok;

  logic          app_head_ok, scan_head_ok, app_fire, pop;
  logic [CW-1:0] app_cnt, scan_cnt;
  logic [HW+PW-1:0] wr_addr, rd_addr;
  word_t         wr_data, rd_raw, byp_data, rd_word, skid_word;
  logic          rd_vld, byp_hit, rd_last;
  logic [PW-1:0] rd_pos;
  logic [1:0]    level;

  assign app_head_ok  = {1'b0, app_head} < NH_L;
  assign scan_head_ok = {1'b0, scan_head} < NH_L;
  assign app_cnt      = app_head_ok ? count[app_head] : '0;
  assign scan_cnt     = scan_head_ok ? count[scan_head] : '0;

`ifdef KV_CACHE_SLIDING_WINDOW_EN
  assign app_ready = !clear && app_head_ok;
  assign scan_base = scan_head_ok ? oldest[scan_head] : '0;
`else
  assign app_ready = !clear && app_head_ok && (app_cnt != FULL_CNT);
  assign scan_base = '0;
`endif

  assign app_fire = app_valid && app_ready;
  assign wr_addr  = {app_head, wptr[app_head]};
  assign wr_data  = '{k: app_k, v: app_v};

  always_ff @(posedge clk or posedge rst) begin
    if (rst || clear) begin
      for (int unsigned h = 0; h < NUM_HEADS; h++) begin
        count[h] <= '0;
        wptr[h]  <= '0;
`ifdef KV_CACHE_SLIDING_WINDOW_EN
        oldest[h] <= '0;
`endif
      end
    end else if (app_fire) begin
      wptr[app_head] <= wptr[app_head] + 1'b1;
`ifdef KV_CACHE_SLIDING_WINDOW_EN
      if (app_cnt == FULL_CNT) oldest[app_head] <= oldest[app_head] + 1'b1;
      else                     count[app_head]  <= count[app_head] + 1'b1;
`else
      count[app_head] <= count[app_head] + 1'b1;
`endif
    end
  end

  always_comb begin
    fill_count = '0;
    for (int unsigned h = 0; h < NUM_HEADS; h++) fill_count[h*CW +: CW] = count[h];
  end

  // Issue only if the beat already in the RAM stage plus the skid contents leave room for one more.
  assign pop        = out_valid && out_ready;
  assign space      = ({1'b0, level} + {2'b0, rd_vld}) <= ({2'b0, pop} + 3'd1);
  assign last_issue = ({1'b0, sc_idx} == (sc_len - 1'b1));
  assign start_ok   = scan_start && scan_head_ok && (scan_cnt != '0);
  assign scan_busy  = (state != IDLE);

  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state)
      IDLE:    if (start_ok) state_d = RUN;
      RUN: begin
        issue = space;
        if (space && last_issue) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      done_d  = 1'b0;
      issue   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      scan_done <= 1'b0;
    end else begin
      state     <= state_d;
      scan_done <= done_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_head <= '0;
      sc_len  <= '0;
      sc_base <= '0;
      sc_idx  <= '0;
    end else if (state == IDLE && start_ok) begin
      sc_head <= scan_head;
      sc_len  <= scan_cnt;
      sc_base <= scan_base;
      sc_idx  <= '0;
    end else if (issue) begin
      sc_idx <= sc_idx + 1'b1;
    end
  end

  assign rd_addr = {sc_head, sc_base + sc_idx};

  always_ff @(posedge clk) begin
    if (app_fire) mem[wr_addr] <= wr_data;
    if (issue)    rd_raw <= mem[rd_addr];
  end

  // Same-edge write to the address being read: remember the write data and substitute it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
      rd_pos   <= '0;
      rd_last  <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (issue) begin
        byp_hit  <= app_fire && (wr_addr == rd_addr);
        byp_data <= wr_data;
        rd_pos   <= sc_idx;
        rd_last  <= last_issue;
      end
    end
  end

  assign rd_word = byp_hit ? byp_data : rd_raw;

  kv_stream_skid #(
    .word_t (word_t),
    .PW     (PW)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .in_valid  (rd_vld),
    .in_word   (rd_word),
    .in_pos    (rd_pos),
    .in_last   (rd_last),
    .level     (level),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (skid_word),
    .out_pos   (out_pos),
    .out_last  (out_last)
  );

  assign out_k = skid_word.k;
  assign out_v = skid_word.v;

endmodule

// File: doc/kv_cache_mh.md
Name: kv_cache_mh

Overview:
Multi-head, append-only key/value cache for the decoder attention datapath.
- Holds DEPTH {K,V} token entries per head, for NUM_HEADS heads, in one packed block-RAM array addressed {head, pos}.
- Writes are token appends through a valid/ready port; reads are whole-head scans streamed out through a valid/ready port with backpressure.
- Sits between the projection units (writers) and the attention score/accumulate engine (reader).

Parameters:
DATA_WIDTH, 16, width of each K and V element
DEPTH, 256, token positions per head; power of two, at least 2
NUM_HEADS, 4, number of heads; at least 1; need not be a power of two
(derived) HW = max(1, $clog2(NUM_HEADS)); PW = $clog2(DEPTH); CW = PW+1

Ports:
clk  in  1  single clock; all logic is rising-edge
rst  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush of all heads
app_valid  in  1  append request
app_ready  out  1  append accepted when app_valid and app_ready are both high
app_head  in  HW  target head of the append
app_k  in  DATA_WIDTH  K data to append
app_v  in  DATA_WIDTH  V data to append
scan_start  in  1  scan request; honoured only when scan_busy=0
scan_head  in  HW  head to scan
scan_busy  out  1  a scan is in progress
scan_done  out  1  one-cycle pulse after the last beat handshakes
out_valid  out  1  stream beat valid
out_ready  in  1  stream consumer ready
out_k  out  DATA_WIDTH  K of the current beat
out_v  out  DATA_WIDTH  V of the current beat
out_pos  out  PW  logical token position of the current beat
out_last  out  1  final beat of the scan
fill_count  out  NUM_HEADS*CW  per-head occupancy; head h occupies bits [h*CW +: CW]

Behaviour:
- Reset (rst=1, asynchronous):
  - all counts and pointers = 0; FSM = IDLE.
  - out_valid, out_k, out_v, out_pos, out_last, scan_busy, scan_done, fill_count = 0.
  - RAM contents are not reset.
- app_ready (combinational) = !clear && app_head < NUM_HEADS && count[app_head] < DEPTH.
- Append accept:
  - writes {app_k, app_v} to address {app_head, wptr[app_head]}.
  - count and wptr for that head increment on the same edge; wptr wraps modulo DEPTH.
- Scan FSM, IDLE -> RUN -> DRAIN -> IDLE:
  - IDLE: scan_start with scan_head < NUM_HEADS and count > 0 snapshots len = count[scan_head] and base = oldest pointer, then enters RUN with scan_busy=1.
  - IDLE: a start on an invalid head or with count = 0 is ignored; no busy, no done.
  - RUN: issues one read address per cycle while the skid buffer has space; moves to DRAIN after address len-1 is issued.
  - DRAIN: when the beat with out_last=1 handshakes, go to IDLE; scan_done=1 for exactly one cycle; scan_busy clears on that same edge.
- Read latency:
  - RAM read is one cycle, followed by a 2-entry skid buffer.
  - With out_ready held high, the first out_valid appears 2 cycles after the scan_start edge, then one beat per cycle with no bubbles.
- Stream rules:
  - out_* are stable while out_valid=1 and out_ready=0.
  - out_pos runs 0..len-1 in order; out_last=1 only when out_pos = len-1.
- Collision: a read of an address written on the same edge returns the new write data (write-first), implemented with a registered bypass.
- Appends that occur during a scan:
  - allowed on any head, including the head being scanned.
  - do not extend the scan, because len is a snapshot.
- clear=1:
  - all counts and pointers go to 0 on the next edge; app_ready=0 during that cycle.
  - any scan aborts: out_valid=0 and scan_busy=0 on the next edge; no scan_done; skid buffer emptied.
  - clear takes priority over a simultaneous scan_start and a simultaneous append.
- Full head: count = DEPTH gives app_ready=0 for that head only; other heads are unaffected.

Optional Feature:
Macro: KV_CACHE_SLIDING_WINDOW_EN
- Defined: the cache is a per-head ring buffer.
  - An append to a full head is accepted (app_ready ignores the full condition) and overwrites the oldest entry.
  - count saturates at DEPTH and the oldest pointer advances by 1.
  - Scans read oldest-to-newest from the snapshotted base, wrapping modulo DEPTH; out_pos stays logical (0 = oldest).
  - An overwrite landing on a not-yet-read entry of an active scan returns the new data (write-first); this behaviour is required.
- Undefined: no wrap; a full head stalls its appends; the oldest pointer is constantly 0.

Decomposition:
- Package kv_cache_pkg: kv_word_t packed struct {k, v}; scan state enum typedef (IDLE/RUN/DRAIN); width helper functions for HW/PW/CW.
- Sub-module kv_stream_skid: 2-entry valid/ready skid buffer that carries {kv_word_t, pos, last} and takes a flush input.
- The RAM is inferred inline in kv_cache_mh.

Test Plan:
- Append to head 0 the values k=0x0100+i, v=0x0200+i for i=0..3, then scan head 0 with out_ready=1 -> 4 beats on consecutive cycles starting at scan_start+2; out_pos 0..3; out_last only on pos 3; scan_done pulses once; fill_count head 0 = 4.
- Fill head 1 to DEPTH=256 -> app_ready=0 for head 1 while head 2 still accepts. With KV_CACHE_SLIDING_WINDOW_EN, 2 further appends are accepted and a scan returns entries 2..257 as out_pos 0..255.
- Scan of 8 entries with out_ready toggling 1,0,0,1,... -> every entry delivered exactly once, in order, and out_* held stable during stalls.
- Append to the scanned head at the same cycle as scan_start -> len excludes the new entry; the scan length is unchanged.
- Assert clear mid-scan after beat 3 of 8 -> out_valid=0 next cycle, no scan_done, all fill_count = 0, then a fresh append succeeds.
- Assert rst mid-scan asynchronously -> all outputs 0 immediately; scan_start on an empty head is then ignored (scan_busy stays 0).
